mul8_acc: RTL
=============

MUL8_ACC -- requirements
Module: mul8_acc

Interface
REQ-001 Parameter LEN, default 8: terms per accumulation vector, legal range 1..255.
REQ-002 Parameter ACC_W, default 24: accumulator width, legal range 16..32.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  product beat present on in_p.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_p  input  16  unsigned 8x8 product from the upstream combinational multiplier.
REQ-008 in_last  input  1  beat closes the vector early; qualified by in_valid.
REQ-009 sclr  input  1  synchronous discard of the partial vector.
REQ-010 out_valid  output  1  out_sum, out_cnt and out_ovf are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  ACC_W  accumulated sum.
REQ-013 out_cnt  output  8  number of terms in out_sum.
REQ-014 out_ovf  output  1  sum exceeded 2^ACC_W-1 at some point in the vector.

Function
REQ-015 The FSM SHALL have exactly two states: ACC and HOLD.
REQ-016 In ACC: in_ready=1, out_valid=0; a beat is accepted when in_valid&in_ready.
REQ-017 An accepted beat SHALL add in_p, zero-extended to ACC_W, to acc and increment cnt.
REQ-018 The first beat of a vector SHALL load acc=in_p and cnt=1, with no dependence on stale acc.
REQ-019 A beat with cnt reaching LEN or in_last=1 SHALL move the FSM to HOLD, so out_valid=1 the cycle after that beat (latency 1).
REQ-020 In HOLD: in_ready=0, out_valid=1, and out_sum, out_cnt, out_ovf SHALL remain stable until out_valid&out_ready.
REQ-021 On out_valid&out_ready: return to ACC, clear acc, cnt and ovf; maximum throughput is one vector per LEN+1 cycles.
REQ-022 sclr in ACC SHALL zero acc, cnt and ovf; a beat handshaken in the same cycle SHALL be consumed and dropped (sclr wins).
REQ-023 sclr in HOLD SHALL be ignored.
REQ-024 Carry out of bit ACC_W-1 on any add SHALL set ovf, sticky for the vector.
REQ-025 in_last on the LEN-th beat SHALL behave identically to the LEN-th beat alone.

Reset
REQ-026 rst_n low SHALL asynchronously force state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=0 while asserted.
REQ-027 Reset asserted mid-vector or in HOLD SHALL discard all partial and pending results.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-029 With MUL8_ACC_SAT_EN defined, an overflowing add SHALL clamp acc to 2^ACC_W-1, set ovf, and keep the clamped value for later beats.
REQ-030 Without MUL8_ACC_SAT_EN, an overflowing add SHALL wrap modulo 2^ACC_W and still set ovf.

Structure
REQ-031 Package mul8_pkg SHALL hold the state enum (ACC, HOLD), the LEN and ACC_W defaults, and the product width constant 16.
REQ-032 One sub-module, mul8_acc_add (ACC_W adder with carry out and SAT clamp), is natural; everything else is inline.

Verification
REQ-033 LEN=8, eight beats of in_p=65025 -> out_sum=520200, out_cnt=8, out_ovf=0, out_valid one cycle after the 8th beat.
REQ-034 Beats 1, 2, 3 with in_last on the third -> out_sum=6, out_cnt=3; the next vector starts at acc=in_p.
REQ-035 out_ready held low for 5 cycles in HOLD -> in_ready=0, outputs stable, no beat accepted; the result is taken on the first cycle out_ready=1.
REQ-036 ACC_W=16, beats 65025 then 1000 -> with MUL8_ACC_SAT_EN out_sum=65535, out_ovf=1; without it out_sum=489, out_ovf=1.
REQ-037 sclr with a beat on the same cycle after 3 beats, then 2 beats of 10 with in_last -> out_sum=20, out_cnt=2.
REQ-038 rst_n pulsed low mid-vector and again in HOLD -> out_valid=0 immediately, cnt=0; the next vector's sum is correct.

Source files
------------

// File: rtl/mul8_pkg.sv
// Shared types and defaults for the mul8_acc product accumulator.
// Build option MUL8_ACC_SAT_EN selects a saturating accumulator.
package mul8_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam int LEN_DEF   = 8;
   localparam int ACC_W_DEF = 24;
   localparam int PROD_W    = 16;

endpackage

// File: rtl/mul8_acc_add.sv
// ACC_W adder with carry out and optional clamp.
// Build option MUL8_ACC_SAT_EN clamps the sum to all ones on carry.
module mul8_acc_add #(
   parameter int ACC_W = 24
) (
   input  logic [ACC_W-1:0] a_i,
   input  logic [ACC_W-1:0] b_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             cy_o
);

   logic [ACC_W-1:0] raw;

   // Full add; carry out flags the overflow of this single add.
   always_comb begin
      {cy_o, raw} = {1'b0, a_i} + {1'b0, b_i};
`ifdef MUL8_ACC_SAT_EN
      sum_o = cy_o ? '1 : raw;
`else
      sum_o = raw;
`endif
   end

endmodule

// File: rtl/mul8_acc.sv
// Accumulates up to LEN 16-bit products per vector, then holds the result.
// Build option MUL8_ACC_SAT_EN selects saturating adds (default: wrap).
module mul8_acc
   import mul8_pkg::*;
#(
   parameter int LEN   = LEN_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_p,
   input  logic              in_last,
   input  logic              sclr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [7:0]        out_cnt,
   output logic              out_ovf
);

   localparam logic [7:0] LEN_C = 8'(LEN);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             rdy_q;

   logic             first;
   logic [ACC_W-1:0] add_a;
   logic [ACC_W-1:0] add_b;
   logic [ACC_W-1:0] add_sum;
   logic             add_cy;
   logic [7:0]       cnt_inc;

   // First beat of a vector ignores whatever sits in acc_q.
   assign first   = (cnt_q == 8'd0);
   assign add_a   = first ? '0 : acc_q;
   assign add_b   = ACC_W'(in_p);
   assign cnt_inc = cnt_q + 8'd1;

   mul8_acc_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .a_i   (add_a),
      .b_i   (add_b),
      .sum_o (add_sum),
      .cy_o  (add_cy)
   );

   assign in_ready  = rdy_q && (state_q == ACC);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = acc_q;
   assign out_cnt   = cnt_q;
   assign out_ovf   = ovf_q;

   // Next-state: accumulate in ACC, wait for the consumer in HOLD.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ACC: begin
            if (sclr) begin
               acc_d = '0;
               cnt_d = 8'd0;
               ovf_d = 1'b0;
            end else if (in_valid && in_ready) begin
               acc_d = add_sum;
               cnt_d = cnt_inc;
               ovf_d = (first ? 1'b0 : ovf_q) | add_cy;
               if (cnt_inc == LEN_C || in_last) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = ACC;
               acc_d   = '0;
               cnt_d   = 8'd0;
               ovf_d   = 1'b0;
            end
         end
      endcase
   end

   // State and datapath registers; reset drops any partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         acc_q   <= '0;
         cnt_q   <= 8'd0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rdy_q   <= 1'b1;
      end
   end

endmodule
